// File: rtl/moore_1101_pkg.sv
// moore_1101_pkg: state encoding and target pattern shared by the 1101 detector.
package moore_1101_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/moore_1101.sv
// moore_1101: Moore-style serial detector for 1101; Y decodes from the state register only.
// Define MOORE_1101_COUNT_EN to add the wrapping match_count output.
module moore_1101
    import moore_1101_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Din,
`ifdef MOORE_1101_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             Y
);

    state_t state, next;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("moore_1101: CNT_W must be at least 1");
    end

    always_ff @(posedge Clk) begin
        if (!Rst) state <= S0;
        else      state <= next;
    end

    // The S4 exit decides overlap: keep the trailing 1 as "11" progress or only as "1".
    always_comb begin
        next = S0;
        case (state)
            S0: next = (Din == PATTERN[3]) ? S1 : S0;
            S1: next = (Din == PATTERN[2]) ? S2 : S0;
            S2: next = (Din == PATTERN[1]) ? S3 : S2;
            S3: next = (Din == PATTERN[0]) ? S4 : S0;
            S4: next = !Din ? S0 : (OVERLAP != 0) ? S2 : S1;
            default: next = S0;
        endcase
    end

    assign Y = (state == S4);

`ifdef MOORE_1101_COUNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst)            match_count <= '0;
        else if (next == S4) match_count <= match_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_moore_1101.sv
// tb_moore_1101: scoreboard bench comparing overlapping and non-overlapping detectors to a suffix model.
module tb_moore_1101;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic Din = 1'b0;
    logic y1, y0;
`ifdef MOORE_1101_COUNT_EN
    logic [1:0] mc1, mc0;
`endif

    always #5 Clk = ~Clk;

    moore_1101 #(.OVERLAP(1), .CNT_W(2)) dut (
        .Clk(Clk), .Rst(Rst), .Din(Din),
`ifdef MOORE_1101_COUNT_EN
        .match_count(mc1),
`endif
        .Y(y1)
    );

    moore_1101 #(.OVERLAP(0), .CNT_W(2)) dut0 (
        .Clk(Clk), .Rst(Rst), .Din(Din),
`ifdef MOORE_1101_COUNT_EN
        .match_count(mc0),
`endif
        .Y(y0)
    );

    typedef struct {
        logic       y1;
        logic       y0;
        logic [1:0] c1;
        logic [1:0] c0;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit h1[$];
    bit h0[$];
    logic [1:0] cnt1, cnt0;

    // Model: a match is the last four bits seen since reset (or since the previous match
    // when overlap is off) reading 1101.
    function automatic bit is_match(input bit h[$]);
        return h.size() == 4 && h[0] && h[1] && !h[2] && h[3];
    endfunction

    task automatic step(input logic r, input logic d);
        exp_t e;
        @(negedge Clk);
        Rst = r;
        Din = d;
        if (!r) begin
            h1.delete();
            h0.delete();
            cnt1 = 2'd0;
            cnt0 = 2'd0;
            e.y1 = 1'b0;
            e.y0 = 1'b0;
        end else begin
            h1.push_back(d);
            if (h1.size() > 4) void'(h1.pop_front());
            e.y1 = is_match(h1);
            if (e.y1) cnt1 = cnt1 + 2'd1;
            h0.push_back(d);
            if (h0.size() > 4) void'(h0.pop_front());
            e.y0 = is_match(h0);
            if (e.y0) begin
                cnt0 = cnt0 + 2'd1;
                h0.delete();
            end
        end
        e.c1 = cnt1;
        e.c0 = cnt0;
        sb.push_back(e);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i] == "1");
    endtask

    task automatic chk(input string n, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", n, cyc, got, exp);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk("y_overlap", {1'b0, y1}, {1'b0, m.y1});
            chk("y_no_overlap", {1'b0, y0}, {1'b0, m.y0});
`ifdef MOORE_1101_COUNT_EN
            chk("count_overlap", mc1, m.c1);
            chk("count_no_overlap", mc0, m.c0);
`endif
        end
    end

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        feed("01010111010101");
        step(1'b0, 1'b0);
        feed("1101101");
        step(1'b0, 1'b1);
        feed("111101");
        step(1'b0, 1'b0);
        feed("110");
        step(1'b0, 1'b1);
        feed("1");
        feed("1101");
        step(1'b0, 1'b0);
        repeat (5) feed("11010");
        repeat (400) step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge Clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moore_1101.md
Name: moore_1101

Overview:
- Serial Moore-machine sequence detector for the bit pattern 1101 on a single-bit input stream.
- Samples Din on each rising Clk edge and asserts Y for one full cycle while the registered state is "pattern complete".
- Sits on serial data paths as a frame/sync marker detector.
- Output depends only on the state register (Moore), so it is glitch-free and has no combinational path from Din.

Parameters:
- OVERLAP, 1, 1 = overlapping matches allowed (the trailing 1 of a match can start the next one); 0 = detector restarts after each match.
- CNT_W, 8, width of the optional match counter (used only when the feature is enabled).

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Rst  input  1  one clock; reset is synchronous and active-low (Rst=0 sampled at a rising Clk edge resets).
- Din  input  1  serial data bit, sampled each rising Clk edge.
- Y  output  1  detect flag; high while the state is S4.
- match_count  output  CNT_W  number of detections; present only with MOORE_1101_COUNT_EN.

Behaviour:
- States, one-hot or binary encoded (implementer's choice; S0 has the encoding value 0):
  - S0: idle, no prefix.
  - S1: seen "1".
  - S2: seen "11".
  - S3: seen "110".
  - S4: seen "1101", Y=1.
- Transitions on the rising Clk edge, with Rst high:
  - S0: Din=1 -> S1; Din=0 -> S0.
  - S1: Din=1 -> S2; Din=0 -> S0.
  - S2: Din=1 -> S2; Din=0 -> S3.
  - S3: Din=1 -> S4; Din=0 -> S0.
  - S4 with OVERLAP=1: Din=1 -> S2; Din=0 -> S0.
  - S4 with OVERLAP=0: Din=1 -> S1; Din=0 -> S0.
- Y = (state == S4), decoded from the state register only.
  - Latency: Y rises one Clk edge after the edge that samples the final 1 of the pattern.
  - Y stays high for exactly one cycle per match. Back-to-back matches are at least 3 cycles apart with OVERLAP=1.
- Reset:
  - Rst=0 at a rising edge forces state to S0, so Y=0 from that edge onward. match_count clears to 0.
  - Reset takes priority over Din.
  - Reset mid-pattern discards the partial prefix; a pattern spanning the reset edge is not detected.
  - Before the first reset edge, state is undefined; the block makes no guarantee.
- Illegal or unreachable encodings go to S0 on the next edge (default branch).
- Din X/Z: not handled; the bench must drive known values.

Optional Feature:
- Macro MOORE_1101_COUNT_EN.
- Defined:
  - Adds output match_count[CNT_W-1:0]. It increments by 1 on each edge where the next state is S4, so it is updated coincident with Y rising.
  - Wraps from all-ones to 0.
  - Cleared by reset.
- Undefined: the port and its logic are absent; the interface is exactly Clk, Rst, Din, Y.

Decomposition:
- Shared package moore_1101_pkg holds:
  - state enum typedef state_t (S0..S4);
  - localparam for the pattern 4'b1101.
- No sub-module needed. Next-state logic and output decode live in one module; the counter is an inline always block under the macro.

Test Plan:
- Reset: hold Rst=0 for 2 edges with Din toggling -> Y=0, state S0, match_count=0.
- Stream 0,1,0,1,0,1,1,1,0,1,0,1,0,1 (one bit per cycle after reset release) -> exactly one Y pulse, in the cycle after the 10th bit (bits 7-10 = 1101); Y=0 elsewhere.
- Overlap, OVERLAP=1, stream 1,1,0,1,1,0,1 -> two Y pulses, after bit 4 and after bit 7. With OVERLAP=0 -> one pulse, after bit 4.
- Long run 1,1,1,1,0,1 -> single Y pulse after bit 6 (S2 self-loop verified).
- Reset mid-operation: drive 1,1,0, assert Rst=0 for one edge, then drive 1 -> no Y pulse. Then 1,1,0,1 -> Y pulse.
- With MOORE_1101_COUNT_EN, CNT_W=2: apply 5 non-overlapping matches -> match_count goes 1,2,3,0,1, each change aligned with Y rising.
